// File: rtl/mem_map_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_map_pkg
//  Purpose  : Address map, MMIO register offsets, bit positions and decode
//             region type shared by the data-side memory responder.
//  Revision : 1.0  initial release
// ============================================================================
package mem_map_pkg;

    // Default byte base addresses of the two decoded windows
    localparam logic [31:0] DEF_RAM_BASE  = 32'h1001_0000;
    localparam logic [31:0] DEF_MMIO_BASE = 32'h1001_0400;
    localparam int          DEF_RAM_DEPTH = 64;

    // MMIO window is five 32-bit words
    localparam int          MMIO_SPAN     = 20;

    // MMIO register offsets relative to the MMIO base
    localparam logic [4:0]  OFS_GPIO_OUT  = 5'h00;
    localparam logic [4:0]  OFS_GPIO_IN   = 5'h04;
    localparam logic [4:0]  OFS_CYCLE_CNT = 5'h08;
    localparam logic [4:0]  OFS_CNT_CTRL  = 5'h0C;
    localparam logic [4:0]  OFS_STATUS    = 5'h10;

    // Bit positions inside CNT_CTRL and STATUS
    localparam int          CTRL_EN       = 0;
    localparam int          CTRL_CLR      = 1;
    localparam int          STATUS_ERR    = 0;

    // Which window an address falls into
    typedef enum logic [1:0] {
        REG_NONE = 2'd0,
        REG_RAM  = 2'd1,
        REG_MMIO = 2'd2
    } region_e;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : Sync_2FF
//  Purpose  : Two-stage flip-flop synchronizer for asynchronous level inputs.
//             Output reflects the input two rising edges later.
//  Revision : 1.0  initial release
// ============================================================================
module Sync_2FF #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // First stage may go metastable; second stage gives it a cycle to settle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder
//  Purpose  : Data-port responder for the pipelined core: word RAM plus a
//             small MMIO bank (GPIO out/in, cycle counter, sticky bus error).
//             Loads are combinational; stores commit on the rising edge.
//  Revision : 1.0  initial release
// ============================================================================
module data_mem_responder
    import mem_map_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RAM_BASE   = ADDR_WIDTH'(DEF_RAM_BASE),
    parameter int                    RAM_DEPTH  = DEF_RAM_DEPTH,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = ADDR_WIDTH'(DEF_MMIO_BASE),
    parameter int                    GPIO_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [ADDR_WIDTH-1:0] RWAddress,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] MemData,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic                  bus_err
);

    localparam int                    c_idx_w     = $clog2(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_ram_span  = ADDR_WIDTH'(4 * RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_mmio_span = ADDR_WIDTH'(MMIO_SPAN);

    // Storage and MMIO state
    logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
    logic [GPIO_WIDTH-1:0] r_gpio_out;
    logic [31:0]           r_cycle_cnt;
    logic                  r_cnt_en;
    logic                  r_err;

    // Decode and next-state wires
    logic [ADDR_WIDTH-1:0] w_ram_off;
    logic [ADDR_WIDTH-1:0] w_mmio_off;
    logic [c_idx_w-1:0]    w_ram_idx;
    logic [4:0]            w_mmio_sel;
    region_e               w_region;
    logic                  w_err;
    logic                  w_ram_wr;
    logic                  w_mmio_wr;
    logic [GPIO_WIDTH-1:0] w_gpio_sync;
    logic [GPIO_WIDTH-1:0] w_gpio_out_nxt;
    logic [31:0]           w_cycle_cnt_nxt;
    logic                  w_cnt_en_nxt;
    logic                  w_err_nxt;

    Sync_2FF #(
        .WIDTH (GPIO_WIDTH)
    ) u_gpio_sync (
        .clk (clk),
        .rst (rst),
        .i_d (gpio_in),
        .o_q (w_gpio_sync)
    );

    assign w_ram_off  = RWAddress - RAM_BASE;
    assign w_mmio_off = RWAddress - MMIO_BASE;
    assign w_ram_idx  = w_ram_off[c_idx_w+1:2];
    assign w_mmio_sel = w_mmio_off[4:0];

    // Address decode and error classification for the current access
    always_comb begin
        w_region = REG_NONE;
        if ((RWAddress >= RAM_BASE) && (w_ram_off < c_ram_span)) begin
            w_region = REG_RAM;
        end else if ((RWAddress >= MMIO_BASE) && (w_mmio_off < c_mmio_span)) begin
            w_region = REG_MMIO;
        end
        // A read and write together is ambiguous, so it is treated as an error
        w_err     = (MemRead || MemWrite) &&
                    ((w_region == REG_NONE) || (RWAddress[1:0] != 2'b00) ||
                     (MemRead && MemWrite));
        w_ram_wr  = MemWrite && !w_err && (w_region == REG_RAM);
        w_mmio_wr = MemWrite && !w_err && (w_region == REG_MMIO);
    end

    // Zero-latency load mux; anything not a clean read returns zero
    always_comb begin
        MemData = '0;
        if (MemRead && !w_err) begin
            case (w_region)
                REG_RAM:  MemData = r_mem[w_ram_idx];
                REG_MMIO: begin
                    case (w_mmio_sel)
                        OFS_GPIO_OUT:  MemData[GPIO_WIDTH-1:0] = r_gpio_out;
                        OFS_GPIO_IN:   MemData[GPIO_WIDTH-1:0] = w_gpio_sync;
                        OFS_CYCLE_CNT: MemData = DATA_WIDTH'(r_cycle_cnt);
                        OFS_CNT_CTRL:  MemData[CTRL_EN] = r_cnt_en;
                        OFS_STATUS:    MemData[STATUS_ERR] = r_err;
                        default:       MemData = '0;
                    endcase
                end
                default:  MemData = '0;
            endcase
        end
    end

    // MMIO next-state: CLR beats increment, new error beats W1C
    always_comb begin
        w_gpio_out_nxt  = r_gpio_out;
        w_cnt_en_nxt    = r_cnt_en;
        w_cycle_cnt_nxt = r_cnt_en ? (r_cycle_cnt + 32'd1) : r_cycle_cnt;
        w_err_nxt       = r_err;
        if (w_mmio_wr) begin
            case (w_mmio_sel)
                OFS_GPIO_OUT: w_gpio_out_nxt = WriteData[GPIO_WIDTH-1:0];
                OFS_CNT_CTRL: begin
                    w_cnt_en_nxt = WriteData[CTRL_EN];
                    if (WriteData[CTRL_CLR]) begin
                        w_cycle_cnt_nxt = '0;
                    end
                end
                OFS_STATUS: begin
                    if (WriteData[STATUS_ERR]) begin
                        w_err_nxt = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        if (w_err) begin
            w_err_nxt = 1'b1;
        end
    end

    // MMIO register bank with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gpio_out  <= '0;
            r_cycle_cnt <= '0;
            r_cnt_en    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_gpio_out  <= w_gpio_out_nxt;
            r_cycle_cnt <= w_cycle_cnt_nxt;
            r_cnt_en    <= w_cnt_en_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // RAM keeps its contents through reset but ignores stores while rst is high
    always_ff @(posedge clk) begin
        if (!rst && w_ram_wr) begin
            r_mem[w_ram_idx] <= WriteData;
        end
    end

    assign gpio_out = r_gpio_out;
    assign bus_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_responder
//  Purpose  : Self-checking bench for data_mem_responder: RAM, GPIO, counter,
//             bus-error and reset behaviour with a queue of expected loads.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] RWAddress;
    logic [31:0] WriteData;
    logic [31:0] MemData;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic        bus_err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got;
    logic [31:0] e;

    localparam logic [31:0] A_GPIO_OUT = 32'h1001_0400;
    localparam logic [31:0] A_GPIO_IN  = 32'h1001_0404;
    localparam logic [31:0] A_CNT      = 32'h1001_0408;
    localparam logic [31:0] A_CTRL     = 32'h1001_040C;
    localparam logic [31:0] A_STATUS   = 32'h1001_0410;

    data_mem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .RWAddress (RWAddress),
        .WriteData (WriteData),
        .MemData   (MemData),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    // Drive one access and stop at the falling edge, where loads are sampled
    task automatic bus(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        MemRead   = rd;
        MemWrite  = wr;
        RWAddress = a;
        WriteData = d;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        RWAddress = '0;
        WriteData = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus(1'b0, 1'b1, a, d);
        tick();
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] data);
        bus(1'b1, 1'b0, a, 32'h0);
        data = MemData;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; RWAddress = '0; WriteData = '0; gpio_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (gpio_out !== 8'h00) begin errors++; $display("FAIL reset_gpio_out: got %h expected 00", gpio_out); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err: got %b expected 0", bus_err); end
        exp_q.push_back(32'h0); rd(A_CNT, got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL reset_cnt: got %h expected %h", got, e); end
    endtask

    task automatic test_ram();
        wr(32'h1001_0008, 32'hDEAD_BEEF);
        exp_q.push_back(32'hDEAD_BEEF); rd(32'h1001_0008, got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL ram_word2: got %h expected %h", got, e); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL ram_no_err: got %b expected 0", bus_err); end
        wr(32'h1001_00FC, 32'h0BAD_F00D);
        exp_q.push_back(32'h0BAD_F00D); rd(32'h1001_00FC, got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL ram_last: got %h expected %h", got, e); end
        exp_q.push_back(32'h0); bus(1'b0, 1'b0, 32'h1001_0008, 32'h0); got = MemData; tick(); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL ram_no_strobe: got %h expected %h", got, e); end
    endtask

    task automatic test_gpio();
        wr(A_GPIO_OUT, 32'h0000_005A);
        checks++; if (gpio_out !== 8'h5A) begin errors++; $display("FAIL gpio_out_pin: got %h expected 5a", gpio_out); end
        exp_q.push_back(32'h0000_005A); rd(A_GPIO_OUT, got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL gpio_out_rd: got %h expected %h", got, e); end
        gpio_in = 8'hC3;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0000_00C3);
        for (int i = 0; i < 3; i++) begin
            rd(A_GPIO_IN, got); e = exp_q.pop_front();
            checks++; if (got !== e) begin errors++; $display("FAIL gpio_in_sync%0d: got %h expected %h", i, got, e); end
        end
        wr(A_GPIO_IN, 32'hFFFF_FFFF);
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL ro_write_err: got %b expected 0", bus_err); end
        exp_q.push_back(32'h0000_00C3); rd(A_GPIO_IN, got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL gpio_in_ro: got %h expected %h", got, e); end
    endtask

    task automatic test_counter();
        // Enable lands on this edge; each later edge adds one
        wr(A_CTRL, 32'h1);
        repeat (10) tick();
        exp_q.push_back(32'd10); rd(A_CNT, got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL cnt_10: got %0d expected %0d", got, e); end
        wr(A_CTRL, 32'h3);
        exp_q.push_back(32'd0); exp_q.push_back(32'd1);
        for (int i = 0; i < 2; i++) begin
            rd(A_CNT, got); e = exp_q.pop_front();
            checks++; if (got !== e) begin errors++; $display("FAIL cnt_clr%0d: got %0d expected %0d", i, got, e); end
        end
        exp_q.push_back(32'h1); rd(A_CTRL, got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL ctrl_rd: got %h expected %h", got, e); end
        wr(A_CTRL, 32'h0);
    endtask

    task automatic test_errors();
        exp_q.push_back(32'h0); bus(1'b1, 1'b0, 32'h2000_0000, 32'h0); got = MemData; e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL unmapped_data: got %h expected %h", got, e); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL err_early: got %b expected 0", bus_err); end
        tick();
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL unmapped_err: got %b expected 1", bus_err); end
        wr(A_STATUS, 32'h1);
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL w1c: got %b expected 0", bus_err); end
        bus(1'b1, 1'b0, 32'h1001_0002, 32'h0); tick();
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL misalign_err: got %b expected 1", bus_err); end
        wr(A_STATUS, 32'h1);
        bus(1'b1, 1'b0, 32'h1001_0100, 32'h0); tick();
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL ram_end_err: got %b expected 1", bus_err); end
        wr(A_STATUS, 32'h1);
        bus(1'b0, 1'b1, 32'h1001_0414, 32'h1); tick();
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL mmio_end_err: got %b expected 1", bus_err); end
        wr(A_STATUS, 32'h1);
        wr(32'h1001_0010, 32'h1111_2222);
        exp_q.push_back(32'h0); bus(1'b1, 1'b1, 32'h1001_0010, 32'hFFFF_0000); got = MemData; tick(); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL both_data: got %h expected %h", got, e); end
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL both_err: got %b expected 1", bus_err); end
        exp_q.push_back(32'h1111_2222); rd(32'h1001_0010, got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL both_ram_kept: got %h expected %h", got, e); end
        exp_q.push_back(32'h1); rd(A_STATUS, got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL status_rd: got %h expected %h", got, e); end
    endtask

    task automatic test_err_priority();
        // ERR is already set; W1C attempts that are themselves errors must not clear it
        bus(1'b0, 1'b1, 32'h1001_0411, 32'h1); tick();
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL prio_misalign: got %b expected 1", bus_err); end
        bus(1'b1, 1'b1, A_STATUS, 32'h1); tick();
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL prio_both: got %b expected 1", bus_err); end
        wr(A_STATUS, 32'h1);
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL prio_clear: got %b expected 0", bus_err); end
    endtask

    task automatic test_reset_mid_op();
        wr(32'h1001_0020, 32'hCAFE_F00D);
        wr(A_CTRL, 32'h1);
        wr(A_GPIO_OUT, 32'hFF);
        bus(1'b1, 1'b0, 32'h2000_0000, 32'h0); tick();
        rst = 1'b1;
        bus(1'b0, 1'b1, A_GPIO_OUT, 32'h77); tick();
        rst = 1'b0;
        checks++; if (gpio_out !== 8'h00) begin errors++; $display("FAIL rst_gpio_out: got %h expected 00", gpio_out); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rst_bus_err: got %b expected 0", bus_err); end
        exp_q.push_back(32'h0); rd(A_GPIO_IN, got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL rst_sync: got %h expected %h", got, e); end
        exp_q.push_back(32'h0); rd(A_CNT, got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL rst_cnt: got %h expected %h", got, e); end
        rst = 1'b1;
        bus(1'b0, 1'b1, 32'h1001_0020, 32'h1234_5678); tick();
        rst = 1'b0;
        exp_q.push_back(32'hCAFE_F00D); rd(32'h1001_0020, got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL rst_ram_kept: got %h expected %h", got, e); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_gpio();
        test_counter();
        test_errors();
        test_err_priority();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-side memory responder serving the pipelined core's data port: `MemRead`, `MemWrite`, `RWAddress`, `WriteData` in; `MemData` out.
- Contains a word-addressed data RAM and a small MMIO register bank: GPIO out, synchronized GPIO in, cycle counter with control, and a sticky bus-error status.
- Read data is combinational so the core samples it in the same memory-stage cycle.
- Writes commit on the rising edge of `clk`.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, address bus width.
- RAM_BASE, 32'h1001_0000, byte base address of data RAM.
- RAM_DEPTH, 64, RAM size in 32-bit words (power of two).
- MMIO_BASE, 32'h1001_0400, byte base address of MMIO bank (5 words).
- GPIO_WIDTH, 8, width of gpio_in and gpio_out.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- MemRead  input  1  read strobe from core memory stage.
- MemWrite  input  1  write strobe from core memory stage.
- RWAddress  input  ADDR_WIDTH  byte address.
- WriteData  input  DATA_WIDTH  store data.
- MemData  output  DATA_WIDTH  load data, combinational.
- gpio_in  input  GPIO_WIDTH  asynchronous external inputs.
- gpio_out  output  GPIO_WIDTH  registered GPIO output.
- bus_err  output  1  sticky bus-error flag (mirror of STATUS[0]).

Behaviour:
- Reset: one clock and reset, as already decided. `clk` is the only clock; `rst` is synchronous and active-high.
  - On rst=1 at a rising edge, clear: gpio_out=0, both synchronizer stages=0, CYCLE_CNT=0, CNT_CTRL=0, STATUS=0, bus_err=0.
  - RAM contents are not cleared.
  - Reset asserted mid-access: the write in that cycle is suppressed for MMIO registers; RAM writes are still gated by rst (suppressed).
- Decode uses RWAddress[1:0] as the alignment check.
  - RAM hit: RAM_BASE <= addr < RAM_BASE+4*RAM_DEPTH. Word index = (addr-RAM_BASE)>>2.
  - MMIO hit: MMIO_BASE <= addr < MMIO_BASE+20.
  - Any other address, or addr[1:0]!=0 with a strobe active, is a bus error.
- Read path: MemData is purely combinational.
  - RAM hit: RAM word.
  - MMIO hit: selected register, zero-extended.
  - MemRead=0 or bus error: 32'h0.
  - Zero-latency: data valid in the same cycle as the address.
- Write path: on the rising edge with MemWrite=1, the valid target is updated from WriteData. Read-during-write to the same word returns the old value.
- MMIO map (offset from MMIO_BASE):
  - 0x00 GPIO_OUT (rw).
  - 0x04 GPIO_IN (ro, output of a 2-FF synchronizer; latency of 2 rising edges from gpio_in).
  - 0x08 CYCLE_CNT (ro, 32-bit).
  - 0x0C CNT_CTRL: bit0 EN (rw); bit1 CLR (write-1, self-clearing, reads 0).
  - 0x10 STATUS: bit0 ERR (write-1-to-clear).
  - Writes to ro registers are ignored and do not set ERR.
- CYCLE_CNT increments by 1 each cycle while EN=1. It wraps 32'hFFFF_FFFF -> 0 with no flag.
  - A CLR write in the same cycle as an increment: clear wins, giving 0 next cycle.
  - Reading CYCLE_CNT returns the current register value (pre-increment).
- ERR is set on the next edge by:
  - any strobed access that misses the map;
  - a misaligned strobed access;
  - MemRead=1 and MemWrite=1 in the same cycle. Here the write is suppressed and MemData=0.
- Set priority over clear: a W1C to STATUS in the same cycle as a new error leaves ERR=1.
- No strobe active: no state change except the counter and the synchronizer.

Decomposition:
- Shared package mem_map_pkg holds:
  - default base constants;
  - MMIO offset localparams (OFS_GPIO_OUT, OFS_GPIO_IN, OFS_CYCLE_CNT, OFS_CNT_CTRL, OFS_STATUS);
  - bit-position constants (CTRL_EN, CTRL_CLR, STATUS_ERR);
  - an enum for decode region {REG_NONE, REG_RAM, REG_MMIO}.
- One sub-module: Sync_2FF (parameterized width, clk/rst) for gpio_in.
- RAM array and MMIO bank stay inline.

Test Plan:
- RAM write then read: MemWrite, addr 0x1001_0008, data 0xDEADBEEF; next cycle MemRead at the same address -> MemData=0xDEADBEEF, bus_err=0. Last word 0x1001_00FC is also writable and readable.
- GPIO: write 0x5A to 0x1001_0400 -> gpio_out=0x5A after the edge. Drive gpio_in=0xC3 -> a read of 0x1001_0404 returns 0x000000C3 from the 2nd edge onward and 0 before.
- Counter: write 1 to 0x1001_040C, wait 10 cycles -> read 0x1001_0408 returns 10 (±the defined edge count). Write 3 (EN+CLR) -> next read 0 then counting resumes. Force value 0xFFFFFFFF -> next value 0.
- Errors: read 0x2000_0000 -> MemData=0, bus_err=1 next edge. Access 0x1001_0002 -> bus_err=1. MemRead and MemWrite both high at 0x1001_0010 -> RAM unchanged, bus_err=1. Write 1 to 0x1001_0410 -> bus_err=0.
- Simultaneous error and W1C: clear STATUS while the same-cycle access is misaligned -> bus_err stays 1.
- Reset mid-op: rst=1 during a MemWrite to GPIO_OUT with the counter running -> gpio_out=0, CYCLE_CNT=0, bus_err=0 after the edge. A previously written RAM word still reads back unchanged.
